// File: rtl/serial_lane_tx_gen_if.sv
// Parallel-word side and serial lane outputs of the multi-lane
// serial transmitter with comma-based lane synchronisation.
interface serial_lane_tx_gen_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
) ();
  logic                   enable;
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   inject_err;
  logic                   ready_out;
  logic [LANES-1:0]       data_out;
  logic                   word_start;
  logic                   sync_done;

  modport master (
    output enable, data_in, valid_in, inject_err,
    input  ready_out, data_out, word_start, sync_done
  );

  modport slave (
    input  enable, data_in, valid_in, inject_err,
    output ready_out, data_out, word_start, sync_done
  );
endinterface

// File: rtl/serial_lane_tx_gen.sv
// Multi-lane MSB-first serialiser: comma preamble per lane, then data
// words with comma filler on idle lanes and forced error-word injection.
module serial_lane_tx_gen #(
  parameter int               LANES      = 2,
  parameter int               WIDTH      = 8,
  parameter int               SYNC_WORDS = 4,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter logic [WIDTH-1:0] ERR_WORD   = 8'h7C
) (
  input logic clk_8f,
  input logic reset,
  serial_lane_tx_gen_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int SW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [BW-1:0]               bit_q, bit_d;
  logic [SW-1:0]               sync_q, sync_d;
  logic [LANES-1:0][WIDTH-1:0] sr_q, sr_d;

  logic             load;
  logic             final_sync;
  logic             ready;
  logic [LANES-1:0] dout;

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sync_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sync_q  <= sync_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    sync_d     = sync_q;
    sr_d       = sr_q;
    load       = (state_q != IDLE) && (bit_q == BW'(WIDTH - 1));
    final_sync = (state_q == SYNC) && (sync_q == SW'(SYNC_WORDS - 1));
    ready      = load && ((state_q == ACTIVE) || final_sync)
                 && bus.enable && !bus.inject_err;

    case (state_q)
      IDLE: begin
        bit_d  = '0;
        sync_d = '0;
        sr_d   = '0;
        if (bus.enable) begin
          for (int i = 0; i < LANES; i++) sr_d[i] = COMMA;
          state_d = SYNC;
        end
      end
      default: begin
        if (load) begin
          bit_d = '0;
          if (!bus.enable) begin
            state_d = IDLE;
            sync_d  = '0;
            sr_d    = '0;
          end else if (!final_sync && (state_q == SYNC)) begin
            for (int i = 0; i < LANES; i++) sr_d[i] = COMMA;
            sync_d = sync_q + SW'(1);
          end else begin
            // Final comma word falls through to the data-load rules.
            state_d = ACTIVE;
            for (int i = 0; i < LANES; i++) begin
              if (bus.inject_err)
                sr_d[i] = ERR_WORD;
              else if (bus.valid_in[i] && ready)
                sr_d[i] = bus.data_in[i*WIDTH +: WIDTH];
              else
                sr_d[i] = COMMA;
            end
          end
        end else begin
          bit_d = bit_q + BW'(1);
          for (int i = 0; i < LANES; i++)
            sr_d[i] = {sr_q[i][WIDTH-2:0], 1'b0};
        end
      end
    endcase

    for (int i = 0; i < LANES; i++) dout[i] = sr_q[i][WIDTH-1];
  end

  assign bus.ready_out  = ready;
  assign bus.data_out   = dout;
  assign bus.word_start = (state_q != IDLE) && (bit_q == '0);
  assign bus.sync_done  = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_lane_tx_gen.sv
// Bench for serial_lane_tx_gen: word-level reference model checked
// every cycle, plus directed word captures and async reset checks.
module tb_serial_lane_tx_gen;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] EW = 8'h7C;

  logic clk;
  logic reset;

  serial_lane_tx_gen_if #(.LANES(2), .WIDTH(8)) bus ();

  serial_lane_tx_gen #(
    .LANES(2), .WIDTH(8), .SYNC_WORDS(4),
    .COMMA(8'hBC), .ERR_WORD(8'h7C)
  ) dut (
    .clk_8f(clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current word, word index
  // since the run started, and the word each lane is transmitting.
  bit         m_run = 1'b0;
  int         m_pos = 0;
  int         m_widx = 0;
  logic [7:0] m_word [2];
  logic [7:0] cap0, cap1;
  logic [7:0] held0, held1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] e_do;
    logic       e_rdy;
    @(negedge clk);
    for (int l = 0; l < 2; l++)
      e_do[l] = m_run ? m_word[l][7-m_pos] : 1'b0;
    e_rdy = m_run && !reset && (m_pos == 7) && (m_widx >= 3)
            && bus.enable && !bus.inject_err;
    chk("data_out", 32'(bus.data_out), 32'(e_do));
    chk("word_start", 32'(bus.word_start), 32'(m_run && m_pos == 0));
    chk("sync_done", 32'(bus.sync_done), 32'(m_run && m_widx >= 4));
    chk("ready_out", 32'(bus.ready_out), 32'(e_rdy));
    cap0 = {cap0[6:0], bus.data_out[0]};
    cap1 = {cap1[6:0], bus.data_out[1]};
    @(posedge clk);
    if (reset) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (bus.enable) begin
        m_run  = 1'b1;
        m_pos  = 0;
        m_widx = 0;
        m_word[0] = BC;
        m_word[1] = BC;
      end
    end else if (m_pos == 7) begin
      if (!bus.enable) begin
        m_run = 1'b0;
      end else begin
        for (int l = 0; l < 2; l++) begin
          if (m_widx < 3)           m_word[l] = BC;
          else if (bus.inject_err)  m_word[l] = EW;
          else if (bus.valid_in[l]) m_word[l] = bus.data_in[l*8 +: 8];
          else                      m_word[l] = BC;
        end
        m_widx++;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    #1;
  endtask

  task automatic word();
    cap0 = '0;
    cap1 = '0;
    repeat (8) tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.data_in    = '0;
    bus.valid_in   = '0;
    bus.inject_err = 1'b0;
    m_word[0] = '0;
    m_word[1] = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Start-up: four commas per lane, first data offered from the start.
    bus.enable   = 1'b1;
    bus.valid_in = 2'b11;
    bus.data_in  = {8'hEE, 8'hFF};
    tick();
    for (int k = 0; k < 4; k++) begin
      word();
      chk("sync_comma_l0", 32'(cap0), 32'(BC));
      chk("sync_comma_l1", 32'(cap1), 32'(BC));
    end

    bus.valid_in = 2'b01;
    bus.data_in  = {8'h55, 8'h99};
    word();
    chk("first_l0", 32'(cap0), 32'h00FF);
    chk("first_l1", 32'(cap1), 32'h00EE);

    held0 = 8'($urandom);
    held1 = 8'($urandom);
    bus.valid_in   = 2'b11;
    bus.data_in    = {held1, held0};
    bus.inject_err = 1'b1;
    word();
    chk("single_l0", 32'(cap0), 32'h0099);
    chk("single_l1", 32'(cap1), 32'(BC));

    bus.inject_err = 1'b0;
    word();
    chk("err_l0", 32'(cap0), 32'(EW));
    chk("err_l1", 32'(cap1), 32'(EW));
    word();
    chk("held_l0", 32'(cap0), 32'(held0));
    chk("held_l1", 32'(cap1), 32'(held1));

    for (int k = 0; k < 24; k++) begin
      bus.valid_in   = 2'($urandom);
      bus.data_in    = 16'($urandom);
      bus.inject_err = ($urandom_range(0, 5) == 0);
      word();
    end

    // Enable dropped mid-word: the word in flight must still complete.
    bus.valid_in   = 2'b11;
    bus.data_in    = 16'($urandom);
    bus.inject_err = 1'b0;
    repeat (2) tick();
    bus.enable = 1'b0;
    repeat (6) tick();
    repeat (6) tick();

    bus.enable = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      word();
      chk("resync_l0", 32'(cap0), 32'(BC));
      chk("resync_l1", 32'(cap1), 32'(BC));
    end
    bus.data_in = 16'($urandom);
    word();
    repeat (3) tick();

    // Asynchronous reset in the middle of a data word.
    reset = 1'b1;
    m_run = 1'b0;
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_sync_done", 32'(bus.sync_done), 32'h0);
    chk("rst_ready_out", 32'(bus.ready_out), 32'h0);
    chk("rst_word_start", 32'(bus.word_start), 32'h0);
    tick();
    reset      = 1'b0;
    bus.enable = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_lane_tx_gen.md
SERIAL_LANE_TX_GEN -- requirements
Module: serial_lane_tx_gen

Interface
REQ-001 Parameter LANES, default 2: number of serial lanes; legal range LANES >= 1.
REQ-002 Parameter WIDTH, default 8: bits per word; legal range WIDTH >= 2.
REQ-003 Parameter SYNC_WORDS, default 4: comma words per lane sent before data; legal range SYNC_WORDS >= 1.
REQ-004 Parameter COMMA, default 8'hBC (WIDTH bits): word used for synchronisation and as filler on idle lanes.
REQ-005 Parameter ERR_WORD, default 8'h7C (WIDTH bits): word used for forced error injection.
REQ-006 Port clk_8f, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port enable, input, 1: run request.
REQ-009 Port data_in, input, LANES*WIDTH: parallel words; lane i uses bits [i*WIDTH +: WIDTH].
REQ-010 Port valid_in, input, LANES: per-lane word valid.
REQ-011 Port inject_err, input, 1: replace the next word on all lanes with ERR_WORD.
REQ-012 Port ready_out, output, 1: word-accept strobe, common to all lanes.
REQ-013 Port data_out, output, LANES: serial bit per lane, MSB first.
REQ-014 Port word_start, output, 1: high while the MSB of a word is on data_out.
REQ-015 Port sync_done, output, 1: high while in ACTIVE.

Function
REQ-016 The FSM shall have states IDLE, SYNC and ACTIVE; a bit counter shall run 0..WIDTH-1; a sync counter shall run 0..SYNC_WORDS-1.
REQ-017 Each lane shall hold a WIDTH-bit shift register; data_out[i] = MSB of that register, driven directly from the flop.
REQ-018 Load cycle: bit counter == WIDTH-1 in SYNC or ACTIVE; on that edge every lane loads a new word and the bit counter returns to 0; on all other edges registers shift left by one, filling with 0, and the counter increments.
REQ-019 IDLE: data_out = 0, counters held at 0; an edge with enable=1 shall load COMMA into all lanes, clear the sync counter and enter SYNC, so the comma MSB appears on the following cycle.
REQ-020 SYNC: at each load cycle with sync counter < SYNC_WORDS-1, load COMMA and increment the sync counter; exactly SYNC_WORDS commas per lane are sent.
REQ-021 SYNC: at the load cycle with sync counter == SYNC_WORDS-1, apply the ACTIVE load rules (REQ-023) and enter ACTIVE.
REQ-022 ready_out = load cycle AND (state ACTIVE OR final SYNC word) AND enable AND NOT inject_err; it is combinational and is low at all other times.
REQ-023 ACTIVE-rule load: lane i loads data_in slice i if valid_in[i] AND ready_out, otherwise COMMA; a word is consumed only where valid_in[i] AND ready_out are both 1.
REQ-024 inject_err=1 on a load cycle in ACTIVE or final SYNC word: all lanes load ERR_WORD; no data consumed; the FSM still advances SYNC->ACTIVE.
REQ-025 enable=0 on any load cycle: all lanes load 0 and the FSM enters IDLE; the word in flight always completes; inject_err is ignored.
REQ-026 enable changes between load cycles shall have no effect until the next load cycle.
REQ-027 word_start = 1 when state != IDLE and bit counter == 0.
REQ-028 sync_done shall be 1 exactly while the state is ACTIVE.
REQ-029 Latency: a word accepted at a load edge has its MSB on data_out for the next clk_8f period and its LSB WIDTH-1 periods later.

Reset
REQ-030 reset=1 shall immediately, regardless of clock, force IDLE, all shift registers 0, all counters 0, data_out=0, word_start=0, sync_done=0, ready_out=0.
REQ-031 Reset mid-word shall discard the partial word; after release the block shall wait in IDLE for enable.

Verification
REQ-032 Reset asserted at bit 3 of a data word -> data_out=2'b00, sync_done=0, ready_out=0 in the same timestep, with no clock edge required.
REQ-033 enable rises after reset -> both lanes send 10111100 four times (32 cycles), word_start is high every 8th cycle, ready_out pulses on the 32nd bit, and sync_done rises on the following edge.
REQ-034 At the first ready_out, valid_in=2'b11, lane0=8'hFF, lane1=8'hEE -> lane0 sends 11111111, lane1 sends 11101110, MSB first, starting the next cycle.
REQ-035 valid_in=2'b01, lane0=8'h99 -> lane0 sends 10011001, lane1 sends COMMA 10111100.
REQ-036 inject_err=1 on a load cycle with valid_in=2'b11 -> ready_out=0, both lanes send 01111100, the held data is sent on the next word with ready_out=1.
REQ-037 enable dropped at bit 2 of a word -> the word completes, then data_out=0, sync_done=0; enable re-asserted -> four commas are sent again before data.
